// File: rtl/digit_serializer.sv
// ----------------------------------------------------------------------------
// digit_serializer
//
// Captures a packed COUNT-digit word in a single cycle, then presents it one
// digit at a time over a valid/ready handshake. The emission order and
// leading-zero suppression are chosen when the word is loaded. This is the
// output-side counterpart of the input unit's digit shift register and
// drives the display/readout path.
//
// Ports:
//   trig      : clock, rising edge active
//   reset     : asynchronous, active-low reset
//   load      : capture request; accepted only while idle (busy=0)
//   dir       : sampled with load; 0 = MSD first, 1 = LSD first
//   blank_lz  : sampled with load; 1 = suppress leading-zero digits
//   in        : packed word, digit k at in[k*WIDTH +: WIDTH]
//   out       : current digit
//   out_idx   : position k of the current digit
//   out_valid : out/out_idx/out_last are valid
//   out_ready : consumer accepts the current digit
//   out_last  : current digit is the final one of the word
//   busy      : serializer is not idle
// ----------------------------------------------------------------------------
module digit_serializer #(
    parameter  int COUNT = 4,
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(COUNT)
) (
    input  logic                   trig,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   dir,
    input  logic                   blank_lz,
    input  logic [COUNT*WIDTH-1:0] in,
    output logic [WIDTH-1:0]       out,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT*WIDTH-1:0] word_q,  word_d;
    logic                   dir_q,   dir_d;
    logic [IDXW-1:0]        idx_q,   idx_d;
    // Position of the digit that carries out_last for the word in flight.
    logic [IDXW-1:0]        end_q,   end_d;

    logic [COUNT-1:0]       digit_nz;
    logic [WIDTH-1:0]       word_digit [COUNT];
    logic [IDXW-1:0]        top_nz;
    logic [IDXW-1:0]        last_pos;
    logic                   at_end;

    // Per-digit views: nonzero flags of the incoming word and an
    // addressable copy of the captured word.
    generate
        for (genvar gi = 0; gi < COUNT; gi++) begin : g_digit
            assign digit_nz[gi]   = |in[gi*WIDTH +: WIDTH];
            assign word_digit[gi] = word_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Highest nonzero digit of the incoming word; an all-zero word yields 0,
    // which makes N=1 so a single zero digit is still emitted.
    always_comb begin
        top_nz = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (digit_nz[k]) begin
                top_nz = IDXW'(k);
            end
        end
    end

    // Highest significant position, i.e. N-1.
    assign last_pos = blank_lz ? top_nz : IDXW'(COUNT - 1);

    assign at_end = (idx_q == end_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        end_d   = end_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    word_d  = in;
                    dir_d   = dir;
                    // MSD-first walks down from N-1 to 0, LSD-first walks
                    // up from 0 to N-1.
                    idx_d   = dir ? '0 : last_pos;
                    end_d   = dir ? last_pos : '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // load is deliberately ignored here, including on the edge
                // of the final transfer.
                if (out_ready) begin
                    if (at_end) begin
                        state_d = IDLE;
                    end else if (dir_q) begin
                        idx_d = idx_q + IDXW'(1);
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge trig or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
        end
    end

    // Outputs come straight from registers, so they hold while idle and
    // read as zero after reset (the cleared word at index 0).
    assign out       = word_digit[idx_q];
    assign out_idx   = idx_q;
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) && at_end;

endmodule

// File: tb/tb_digit_serializer.sv
module tb_digit_serializer;

    localparam int COUNT = 4;
    localparam int WIDTH = 4;
    localparam int IDXW  = 2;

    logic                   trig = 1'b0;
    logic                   reset = 1'b0;
    logic                   load = 1'b0;
    logic                   dir = 1'b0;
    logic                   blank_lz = 1'b0;
    logic [COUNT*WIDTH-1:0] in = '0;
    logic [WIDTH-1:0]       out;
    logic [IDXW-1:0]        out_idx;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   out_last;
    logic                   busy;

    digit_serializer #(.COUNT(COUNT), .WIDTH(WIDTH)) dut (
        .trig      (trig),
        .reset     (reset),
        .load      (load),
        .dir       (dir),
        .blank_lz  (blank_lz),
        .in        (in),
        .out       (out),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 trig = ~trig;

    typedef struct {
        int d;
        int idx;
        int last;
    } exp_t;

    exp_t sb[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge trig);
        #1;
    endtask

    // Reference model: expected digit stream for one load.
    task automatic push_expected(input logic [15:0] word, input bit d, input bit blz);
        int dig[COUNT];
        int n;
        exp_t e;
        n = COUNT;
        for (int k = 0; k < COUNT; k++) dig[k] = int'((word >> (k*WIDTH)) & 16'hF);
        if (blz) begin
            n = 1;
            for (int k = 0; k < COUNT; k++) if (dig[k] != 0) n = k + 1;
        end
        if (!d) begin
            for (int k = n - 1; k >= 0; k--) begin
                e.d = dig[k]; e.idx = k; e.last = (k == 0) ? 1 : 0;
                sb.push_back(e);
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                e.d = dig[k]; e.idx = k; e.last = (k == n - 1) ? 1 : 0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_load(input logic [15:0] word, input bit d, input bit blz);
        push_expected(word, d, blz);
        in = word; dir = d; blank_lz = blz; load = 1'b1;
        tick();
        load = 1'b0;
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_busy", int'(busy), 1);
    endtask

    // Run until idle; returns the number of cycles the word took.
    task automatic drain(input bit bp, input bit hold, output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            out_ready = bp ? ~out_ready : 1'b1;
            if (hold) begin
                load = 1'b1;
                in = 16'h9999;
            end
            tick();
            cyc++;
        end
        chk("drain_timeout", int'(busy), 0);
        load = 1'b0;
        out_ready = 1'b1;
        chk("idle_valid", int'(out_valid), 0);
    endtask

    // Monitor: sampled on the falling edge; a transfer happens on the next
    // rising edge when out_valid and out_ready are both high.
    bit               stall_pending = 1'b0;
    logic [WIDTH-1:0] held_out;
    logic [IDXW-1:0]  held_idx;
    logic             held_last;

    initial begin
        exp_t e;
        forever begin
            @(negedge trig);
            if (reset) begin
                if (stall_pending) begin
                    chk("hold_out", int'(out), int'(held_out));
                    chk("hold_idx", int'(out_idx), int'(held_idx));
                    chk("hold_last", int'(out_last), int'(held_last));
                    chk("hold_valid", int'(out_valid), 1);
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("digit", int'(out), e.d);
                        chk("idx", int'(out_idx), e.idx);
                        chk("last", int'(out_last), e.last);
                        $display("xfer digit=%0d idx=%0d last=%0d", out, out_idx, out_last);
                    end
                end
                stall_pending = out_valid && !out_ready;
                held_out  = out;
                held_idx  = out_idx;
                held_last = out_last;
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    initial begin
        int cyc;

        // Reset then idle.
        reset = 1'b0;
        tick(); tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_last", int'(out_last), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_out", int'(out), 0);
            chk("idle_idx", int'(out_idx), 0);
        end

        // MSD-first full word at full throughput.
        out_ready = 1'b1;
        do_load(16'h1234, 1'b0, 1'b0);
        drain(1'b0, 1'b0, cyc);
        chk("msd_cycles", cyc, 4);

        // LSD-first with backpressure.
        out_ready = 1'b1;
        do_load(16'h1234, 1'b1, 1'b0);
        drain(1'b1, 1'b0, cyc);
        chk("lsd_bp_cycles", cyc, 8);

        // Leading-zero suppression.
        do_load(16'h0057, 1'b0, 1'b1);
        drain(1'b0, 1'b0, cyc);
        chk("lz_msd_cycles", cyc, 2);
        do_load(16'h0057, 1'b1, 1'b1);
        drain(1'b0, 1'b0, cyc);
        chk("lz_lsd_cycles", cyc, 2);
        do_load(16'h0000, 1'b0, 1'b1);
        drain(1'b0, 1'b0, cyc);
        chk("zero_cycles", cyc, 1);
        do_load(16'hA0F0, 1'b0, 1'b1);
        drain(1'b0, 1'b0, cyc);
        chk("hex_cycles", cyc, 4);

        // Load held high while busy, through the final transfer edge.
        do_load(16'h1234, 1'b0, 1'b0);
        drain(1'b0, 1'b1, cyc);
        chk("busy_load_cycles", cyc, 4);
        tick();
        chk("busy_load_idle", int'(busy), 0);
        do_load(16'h9999, 1'b0, 1'b0);
        drain(1'b0, 1'b0, cyc);
        chk("nines_cycles", cyc, 4);

        // Reset mid-word after digit 2 transfers.
        do_load(16'h1234, 1'b0, 1'b0);
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_out", int'(out), 0);
        chk("arst_idx", int'(out_idx), 0);
        chk("arst_pending", sb.size(), 2);
        sb.delete();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", int'(out_valid), 0);
        end
        do_load(16'h0008, 1'b0, 1'b1);
        drain(1'b0, 1'b0, cyc);
        chk("eight_cycles", cyc, 1);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/digit_serializer.md
Name: digit_serializer

Overview:
- Output-side counterpart of the input unit's digit shift register.
- Captures a packed COUNT-digit word (WIDTH bits per digit) in one cycle, then emits it one digit at a time over a valid/ready handshake.
- Feeds the display and readout path.
- Emission order and optional leading-zero suppression are chosen at load time.

Parameters:
- COUNT, 4, number of digits in the packed word (COUNT >= 2).
- WIDTH, 4, bits per digit.
- IDXW, $clog2(COUNT), width of digit-index output (derived; not overridden).

Ports:
- trig  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-low reset
- load  input  1  request to capture in; accepted only when busy=0
- dir  input  1  order, sampled with load: 0 = most-significant digit first, 1 = least-significant digit first
- blank_lz  input  1  sampled with load: 1 = suppress leading-zero digits
- in  input  COUNT*WIDTH  packed word; digit k occupies in[k*WIDTH +: WIDTH]; digit COUNT-1 is most significant
- out  output  WIDTH  current digit
- out_idx  output  IDXW  digit position k of the current digit
- out_valid  output  1  out/out_idx/out_last are valid
- out_ready  input  1  consumer accepts the current digit
- out_last  output  1  current digit is the final one of the word
- busy  output  1  serializer is not idle

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE; out=0, out_idx=0, out_valid=0, out_last=0, busy=0; captured word cleared. Outputs stay at these values until the first accepted load.
- FSM states: IDLE and SEND.
- IDLE:
  - busy=0, out_valid=0; out/out_idx hold their last values.
  - On a rising edge with load=1: capture in, dir and blank_lz; go to SEND.
- Significant-digit count N, computed from the captured word at load:
  - blank_lz=0: N=COUNT.
  - blank_lz=1: N = (index of highest nonzero digit)+1.
  - All digits zero: N=1, so a single 0 is always emitted.
- Emission sequence:
  - dir=0: positions N-1 down to 0.
  - dir=1: positions 0 up to N-1.
  - Suppressed digits are never presented.
- SEND:
  - busy=1, out_valid=1.
  - out = captured digit at out_idx; out_last=1 exactly on the N-th digit.
  - First digit is valid in the cycle immediately after the load edge (latency 1).
  - A transfer occurs on a rising edge where out_valid=1 and out_ready=1. Next cycle presents the next digit: throughput 1 digit/cycle with out_ready held high.
  - While out_ready=0: out, out_idx and out_last hold stable; out_valid does not drop.
  - Transfer with out_last=1: next state IDLE; out_valid=0 and busy=0 the following cycle.
  - Total: N digits in exactly N transfers.
- load while busy=1 is ignored. This includes the edge of the final transfer; a new load is accepted no earlier than the first IDLE cycle.
- in, dir and blank_lz changes after the load edge have no effect on the word in flight.
- COUNT=... N=1 case: the first digit has out_last=1 and returns to IDLE after one transfer.
- Reset asserted mid-word: sequence aborted immediately, no further digits emitted, reset values apply. After reset releases, the block stays IDLE until load.
- No arithmetic on digit values; digits pass through unmodified. Values above 9 are legal and emitted as-is.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, load=0 for 5 cycles -> out_valid=0, busy=0, out=0 throughout.
- MSD-first, full word: in=16'h1234, dir=0, blank_lz=0, out_ready=1 -> digits 1,2,3,4 with out_idx 3,2,1,0 on 4 consecutive cycles starting 1 cycle after load; out_last only on 4; busy falls the cycle after.
- LSD-first with backpressure: in=16'h1234, dir=1, out_ready toggling 0,1 -> sequence 4,3,2,1 with out_idx 0..3; each digit held stable while out_ready=0; exactly 4 transfers.
- Leading-zero suppression:
  - in=16'h0057, blank_lz=1, dir=0 -> 5,7 only, out_last on 7.
  - dir=1 -> 7,5.
  - in=16'h0000, blank_lz=1 -> single 0 with out_last=1.
- Load while busy: load 16'h1234, assert load with in=16'h9999 on every cycle including the final-transfer edge -> output 1,2,3,4 unaffected. Next load accepted only when busy=0; then 9,9,9,9.
- Reset mid-word: in=16'h1234, dir=0, reset=0 asynchronously after digit 2 transfers -> out_valid=0, busy=0, out=0 immediately. No digits 3/4 after release. Fresh load of 16'h0008 with blank_lz=1 -> single 8.
